// File: rtl/survivor_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : survivor_decoder
//  Description : Final Viterbi stage. At the last trellis step of a frame it
//                selects the minimum-metric state, queues that state's
//                survivor register in a small frame FIFO and streams it out
//                MSB first on a valid/ready serial interface.
//  Ports       : clk, rst (sync, active-high), flush (sync clear)
//                valid_in, metric_00..11, survivor_00..11, write_ptr_in
//                  - compare-select stage outputs
//                dout, dout_valid, dout_ready, frame_start, frame_end
//                  - serial decoded bit stream
//                best_state, best_metric - result of the last captured frame
//                overflow - sticky frame-drop flag
//  Revision    : 1.0 - initial release
// ============================================================================
module survivor_decoder #(
    parameter int PM_W   = 4,
    parameter int PATH_W = 8,
    parameter int PTR_W  = 3,
    parameter int FDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [PM_W-1:0]   metric_00,
    input  logic [PM_W-1:0]   metric_01,
    input  logic [PM_W-1:0]   metric_10,
    input  logic [PM_W-1:0]   metric_11,
    input  logic [PATH_W-1:0] survivor_00,
    input  logic [PATH_W-1:0] survivor_01,
    input  logic [PATH_W-1:0] survivor_10,
    input  logic [PATH_W-1:0] survivor_11,
    input  logic [PTR_W-1:0]  write_ptr_in,
    output logic              dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_start,
    output logic              frame_end,
    output logic [1:0]        best_state,
    output logic [PM_W-1:0]   best_metric,
    output logic              overflow
);

    localparam int c_AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int c_CW = $clog2(FDEPTH + 1);

    localparam logic [PTR_W-1:0] c_LAST_STEP = PTR_W'(PATH_W - 1);
    localparam logic [c_AW-1:0]  c_LAST_SLOT = c_AW'(FDEPTH - 1);
    localparam logic [c_CW-1:0]  c_FULL      = c_CW'(FDEPTH);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SHIFT = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [PATH_W-1:0] r_shreg;
    logic [PTR_W-1:0]  r_bitcnt;

    logic [PATH_W-1:0] r_fifo [FDEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic              w_capture;
    logic [1:0]        w_best_state;
    logic [PM_W-1:0]   w_best_metric;
    logic [PATH_W-1:0] w_sel_survivor;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_shift;
    logic              w_push;
    logic              w_drop;

    assign w_capture = valid_in && (write_ptr_in == c_LAST_STEP);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_FULL);

    // A full FIFO still accepts a frame when the head leaves on the same edge.
    assign w_push = w_capture && (!w_full || w_pop);
    assign w_drop = w_capture && w_full && !w_pop;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best_state  = 2'd0;
        w_best_metric = metric_00;
        if (metric_01 < w_best_metric) begin
            w_best_state  = 2'd1;
            w_best_metric = metric_01;
        end
        if (metric_10 < w_best_metric) begin
            w_best_state  = 2'd2;
            w_best_metric = metric_10;
        end
        if (metric_11 < w_best_metric) begin
            w_best_state  = 2'd3;
            w_best_metric = metric_11;
        end
    end

    always_comb begin
        w_sel_survivor = survivor_00;
        case (w_best_state)
            2'd1:    w_sel_survivor = survivor_01;
            2'd2:    w_sel_survivor = survivor_10;
            2'd3:    w_sel_survivor = survivor_11;
            default: w_sel_survivor = survivor_00;
        endcase
    end

    // FSM next state, pop/shift strobes and serial outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift     = 1'b0;
        dout_valid  = 1'b0;
        dout        = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                dout_valid  = 1'b1;
                dout        = r_shreg[PATH_W-1];
                frame_start = (r_bitcnt == '0);
                frame_end   = (r_bitcnt == c_LAST_STEP);
                if (dout_ready) begin
                    w_shift = 1'b1;
                    if (r_bitcnt == c_LAST_STEP) begin
                        // Next frame follows without a bubble when one is queued.
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_nxt = c_S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (w_pop) begin
            r_shreg  <= r_fifo[r_rd_ptr];
            r_bitcnt <= '0;
        end else if (w_shift) begin
            r_shreg  <= {r_shreg[PATH_W-2:0], 1'b0};
            r_bitcnt <= r_bitcnt + PTR_W'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_fifo[r_wr_ptr] <= w_sel_survivor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_SLOT) ? '0 : r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_SLOT) ? '0 : r_rd_ptr + c_AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overflow <= 1'b0;
        end else if (w_drop) begin
            overflow <= 1'b1;
        end
    end

    // A dropped frame still reports its result; a flushed capture does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_state  <= 2'd0;
            best_metric <= '0;
        end else if (w_capture && !flush) begin
            best_state  <= w_best_state;
            best_metric <= w_best_metric;
        end
    end

endmodule
`default_nettype wire
